// File: rtl/pipe_add_pkg.sv
// pipe_add_pkg
// Shared helpers for the pipelined adder: derives the pipeline depth from the
// operand width and slice width, and validates that combination.
// No ports (package).
package pipe_add_pkg;

    // Number of ripple slices, which is also the number of pipeline stages.
    function automatic int calc_stages(input int w, input int chunk);
        return w / chunk;
    endfunction

    // True when the operand width splits evenly into whole slices.
    function automatic bit params_ok(input int w, input int chunk);
        return (chunk > 0) && (w >= chunk) && ((w % chunk) == 0);
    endfunction

endpackage

// File: rtl/pipe_add_chunk.sv
// add_chunk
// Combinational N-bit ripple slice used once per pipeline stage.
// Ports:
//   a, b   in  N  slice operands (b already inverted for subtract)
//   cin    in  1  carry into bit 0 of the slice
//   sum    out N  slice sum
//   cout   out 1  carry out of the slice MSB
//   c_msb  out 1  carry into the slice MSB (used for signed overflow)
module add_chunk
    import pipe_add_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [N:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign sum  = full[N-1:0];
    assign cout = full[N];

    // The carry into the MSB is the carry out of the lower N-1 bits; a
    // one-bit slice has no lower bits, so it is simply the slice carry-in.
    generate
        if (N == 1) begin : g_one_bit
            assign c_msb = cin;
        end else begin : g_multi_bit
            logic [N-1:0] low;
            assign low   = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]} + {{(N-1){1'b0}}, cin};
            assign c_msb = low[N-1];
        end
    endgenerate

endmodule

// File: rtl/pipe_add.sv
// pipe_add
// Pipelined W-bit adder/subtractor built from W/CHUNK carry-chained slices,
// one slice per stage, with valid/ready handshakes on input and output.
// Ports:
//   clk        in  1  clock, rising edge
//   reset      in  1  asynchronous active-high reset (clears valid bits only)
//   in_valid   in  1  operation offered
//   in_ready   out 1  operation accepted when in_valid && in_ready
//   a, b       in  W  operands
//   cin        in  1  carry-in, ignored when sub=1
//   sub        in  1  0: a+b+cin, 1: a-b
//   out_valid  out 1  result present
//   out_ready  in  1  downstream accepts result
//   sum        out W  result modulo 2^W
//   cout       out 1  unsigned carry-out (no-borrow for subtract)
//   ovf        out 1  signed overflow
module pipe_add
    import pipe_add_pkg::*;
#(
    parameter int W     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int STAGES = calc_stages(W, CHUNK);

    generate
        if (!params_ok(W, CHUNK)) begin : g_bad_params
            $error("pipe_add: W must be a non-zero multiple of CHUNK");
        end
    endgenerate

    // Per-stage registers. Operand skew registers are kept full width so
    // every stage indexes its slice the same way; the low slices a stage has
    // already consumed are never read and fall away in synthesis.
    logic [STAGES-1:0][W-1:0] a_pipe;
    logic [STAGES-1:0][W-1:0] b_pipe;
    logic [STAGES-1:0][W-1:0] sum_pipe;
    logic [STAGES-1:0]        carry_pipe;
    logic [STAGES-1:0]        c_msb_pipe;
    logic [STAGES-1:0]        valid_pipe;

    // Combinational slice inputs/outputs, one entry per stage.
    logic [STAGES-1:0][CHUNK-1:0] op_a;
    logic [STAGES-1:0][CHUNK-1:0] op_b;
    logic [STAGES-1:0]            op_c;
    logic [STAGES-1:0][CHUNK-1:0] chunk_sum;
    logic [STAGES-1:0]            chunk_cout;
    logic [STAGES-1:0]            chunk_c_msb;

    logic         en;
    logic [W-1:0] b_eff;
    logic         cin_eff;

    // Subtract is A + ~B + 1; the +1 rides in on the stage-0 carry.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;

    // Whole pipe advances together; a stalled output freezes every stage.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign op_a[gi] = a[CHUNK-1:0];
                assign op_b[gi] = b_eff[CHUNK-1:0];
                assign op_c[gi] = cin_eff;
            end else begin : g_rest
                assign op_a[gi] = a_pipe[gi-1][gi*CHUNK +: CHUNK];
                assign op_b[gi] = b_pipe[gi-1][gi*CHUNK +: CHUNK];
                assign op_c[gi] = carry_pipe[gi-1];
            end

            add_chunk #(
                .N(CHUNK)
            ) u_add (
                .a    (op_a[gi]),
                .b    (op_b[gi]),
                .cin  (op_c[gi]),
                .sum  (chunk_sum[gi]),
                .cout (chunk_cout[gi]),
                .c_msb(chunk_c_msb[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_pipe <= '0;
        end else if (en) begin
            valid_pipe[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                valid_pipe[k] <= valid_pipe[k-1];
            end
        end
    end

    // Data registers carry no reset; their contents are qualified by valid.
    always_ff @(posedge clk) begin
        if (en) begin
            a_pipe[0]     <= a;
            b_pipe[0]     <= b_eff;
            sum_pipe[0]   <= W'(chunk_sum[0]);
            carry_pipe[0] <= chunk_cout[0];
            c_msb_pipe[0] <= chunk_c_msb[0];
            for (int k = 1; k < STAGES; k++) begin
                a_pipe[k]                       <= a_pipe[k-1];
                b_pipe[k]                       <= b_pipe[k-1];
                sum_pipe[k]                     <= sum_pipe[k-1];
                sum_pipe[k][k*CHUNK +: CHUNK]   <= chunk_sum[k];
                carry_pipe[k]                   <= chunk_cout[k];
                c_msb_pipe[k]                   <= chunk_c_msb[k];
            end
        end
    end

    assign out_valid = valid_pipe[STAGES-1];
    assign sum       = sum_pipe[STAGES-1];
    assign cout      = carry_pipe[STAGES-1];
    assign ovf       = carry_pipe[STAGES-1] ^ c_msb_pipe[STAGES-1];

    // Skew bits that no stage reads; gathered here so they are consumed.
    logic unused_skew;
    assign unused_skew = ^{a_pipe, b_pipe, c_msb_pipe};

endmodule

// File: tb/tb_pipe_add.sv
module tb_pipe_add;

    localparam int ST32 = 4;
    localparam int ST16 = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        bit          lat;
        int          acc;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    exp_t e32, e16;

    // 32-bit, 8-bit slice instance
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, sum;

    pipe_add #(.W(32), .CHUNK(8)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    // 16-bit, single-stage instance
    logic        h_in_valid, h_in_ready, h_cin, h_sub, h_out_valid, h_out_ready, h_cout, h_ovf;
    logic [15:0] h_a, h_b, h_sum;

    pipe_add #(.W(16), .CHUNK(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .cin(h_cin), .sub(h_sub), .out_valid(h_out_valid),
        .out_ready(h_out_ready), .sum(h_sum), .cout(h_cout), .ovf(h_ovf)
    );

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic send32(input logic [31:0] va, input logic [31:0] vb, input logic vcin,
                          input logic vsub, input logic [31:0] es, input logic ec,
                          input logic eo, input bit lat);
        bit ok;
        ok = 1'b0;
        a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            q32.push_back('{es, ec, eo, lat, cyc + 1});
        end else begin
            checks++;
            errors++;
            $display("FAIL accept32: in_ready stayed 0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send16(input logic [15:0] va, input logic [15:0] vb, input logic vcin,
                          input logic vsub, input logic [15:0] es, input logic ec,
                          input logic eo, input bit lat);
        bit ok;
        ok = 1'b0;
        h_a = va; h_b = vb; h_cin = vcin; h_sub = vsub; h_in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (h_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            q16.push_back('{32'(es), ec, eo, lat, cyc + 1});
        end else begin
            checks++;
            errors++;
            $display("FAIL accept16: in_ready stayed 0, expected 1");
        end
        @(posedge clk);
        #1;
        h_in_valid = 1'b0;
    endtask

    task automatic drain32();
        for (int n = 0; n < 100 && q32.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        if (q32.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain32: %0d results outstanding, expected 0", q32.size());
        end
    endtask

    task automatic drain16();
        for (int n = 0; n < 100 && q16.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        if (q16.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain16: %0d results outstanding, expected 0", q16.size());
        end
    endtask

    // Monitor for the 32-bit instance: handshake rule, stall stability, scoreboard.
    logic [31:0] held_sum;
    logic        held_c, held_o;
    bit          held_v = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            held_v = 1'b0;
        end else begin
            expect_eq("in_ready32", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (held_v && out_valid) begin
                expect_eq("hold_sum32", sum, held_sum);
                expect_eq("hold_cout32", 32'(cout), 32'(held_c));
                expect_eq("hold_ovf32", 32'(ovf), 32'(held_o));
            end
            held_v   = out_valid && !out_ready;
            held_sum = sum;
            held_c   = cout;
            held_o   = ovf;
            if (out_valid && out_ready) begin
                if (q32.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected32: got result %h, expected none", sum);
                end else begin
                    e32 = q32.pop_front();
                    expect_eq("sum32", sum, e32.s);
                    expect_eq("cout32", 32'(cout), 32'(e32.c));
                    expect_eq("ovf32", 32'(ovf), 32'(e32.o));
                    if (e32.lat) expect_eq("latency32", 32'(cyc), 32'(e32.acc + ST32 - 1));
                    $display("dut32 result sum=%h cout=%b ovf=%b (want %h %b %b)",
                             sum, cout, ovf, e32.s, e32.c, e32.o);
                end
            end
        end
    end

    // Monitor for the 16-bit single-stage instance.
    always @(negedge clk) begin
        if (!reset && h_out_valid && h_out_ready) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected16: got result %h, expected none", h_sum);
            end else begin
                e16 = q16.pop_front();
                expect_eq("sum16", 32'(h_sum), e16.s);
                expect_eq("cout16", 32'(h_cout), 32'(e16.c));
                expect_eq("ovf16", 32'(h_ovf), 32'(e16.o));
                if (e16.lat) expect_eq("latency16", 32'(cyc), 32'(e16.acc + ST16 - 1));
                $display("dut16 result sum=%h cout=%b ovf=%b (want %h %b %b)",
                         h_sum, h_cout, h_ovf, e16.s[15:0], e16.c, e16.o);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_a = '0; h_b = '0; h_cin = 1'b0; h_sub = 1'b0; h_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        expect_eq("reset_out_valid32", 32'(out_valid), 32'd0);
        expect_eq("reset_out_valid16", 32'(h_out_valid), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Isolated ops, each with exact latency
        send32(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1); drain32();
        send32(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1); drain32();
        send32(32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b1); drain32();
        send32(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1); drain32();
        send32(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1); drain32();
        send32(32'h000000FF, 32'h00000000, 1'b1, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b1); drain32();
        send32(32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b1); drain32();
        send32(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b1); drain32();

        // Back-to-back stream with a 3-cycle output stall in the middle
        fork
            begin
                send32(32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0);
                send32(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0);
                send32(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
                send32(32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0);
                send32(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0);
                send32(32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
                send32(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
                send32(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain32();

        // Reset with the pipe full: in-flight ops must vanish
        out_ready = 1'b0;
        send32(32'h00000011, 32'h00000001, 1'b0, 1'b0, 32'h00000012, 1'b0, 1'b0, 1'b0);
        send32(32'h00000022, 32'h00000002, 1'b0, 1'b0, 32'h00000024, 1'b0, 1'b0, 1'b0);
        send32(32'h00000033, 32'h00000003, 1'b0, 1'b0, 32'h00000036, 1'b0, 1'b0, 1'b0);
        send32(32'h00000044, 32'h00000004, 1'b0, 1'b0, 32'h00000048, 1'b0, 1'b0, 1'b0);
        expect_eq("fill_out_valid32", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        expect_eq("async_reset_out_valid32", 32'(out_valid), 32'd0);
        q32.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        send32(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1);
        send32(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);
        drain32();

        // Single-stage configuration, one op per cycle
        send16(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        send16(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        send16(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        drain16();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
